// File: rtl/decode_seq.sv
// Instruction decoder with an internal Q1..Q4 phase sequencer, skip and branch flush control.
// Optional macro DECODE_SKIP_EN enables DECFSZ/INCFSZ/BTFSC/BTFSS skipping.
module decode_seq #(
   parameter int FAW = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FAW+6:0]   instr_in,
   input  logic             zero_in,
   output logic [1:0]       phase,
   output logic [3:0]       alu_op,
   output logic             d,
   output logic             sel_k,
   output logic             ram_en,
   output logic             write_en,
   output logic             pc_load,
   output logic [FAW-1:0]   f_addr,
   output logic [2:0]       bit_num,
   output logic [FAW+2:0]   k,
   output logic             skip_taken
);

   localparam int IW = FAW + 7;
   localparam int KW = FAW + 3;

   typedef enum logic {EXEC, FLUSH} state_t;

   state_t          state, state_next;
   logic [IW-1:0]   ir;
   logic            wr_q, pcl_q;

   logic [3:0]      dec_alu;
   logic            dec_d, dec_sel_k, dec_ram_en, dec_wr, dec_pcl;

   logic [1:0]      cur_cls;
   logic [3:0]      cur_op;
   logic            cur_branch, cur_skip;

   // Decode of the word about to be latched; registered on the edge entering Q1.
   always_comb begin
      dec_alu    = 4'd1;
      dec_d      = 1'b0;
      dec_sel_k  = 1'b0;
      dec_ram_en = 1'b0;
      dec_wr     = 1'b0;
      dec_pcl    = 1'b0;
      case (instr_in[IW-1:IW-2])
         2'b00: begin
            dec_ram_en = 1'b1;
            dec_d      = instr_in[FAW];
            dec_wr     = 1'b1;
            case (instr_in[IW-3:IW-6])
               4'b0111: dec_alu = 4'd2;
               4'b0101: dec_alu = 4'd4;
               4'b0001: dec_alu = 4'd9;
               4'b1001: dec_alu = 4'd12;
               4'b0011: dec_alu = 4'd6;
               4'b1010: dec_alu = 4'd5;
               4'b0100: dec_alu = 4'd10;
               4'b1000: dec_alu = 4'd0;
               4'b0000: dec_alu = 4'd1;
               4'b1101: dec_alu = 4'd8;
               4'b1100: dec_alu = 4'd15;
               4'b0010: dec_alu = 4'd3;
               4'b1110: dec_alu = 4'd11;
               4'b0110: dec_alu = 4'd7;
               4'b1011: dec_alu = 4'd6;
               default: dec_alu = 4'd5;
            endcase
         end
         2'b01: begin
            case (instr_in[IW-3:IW-4])
               2'b00: begin
                  dec_alu = 4'd14; dec_ram_en = 1'b1; dec_d = 1'b1; dec_wr = 1'b1;
               end
               2'b01: begin
                  dec_alu = 4'd13; dec_ram_en = 1'b1; dec_d = 1'b1; dec_wr = 1'b1;
               end
               default: begin
`ifdef DECODE_SKIP_EN
                  dec_ram_en = 1'b1;
                  dec_d      = 1'b1;
`endif
               end
            endcase
         end
         2'b11: begin
            dec_sel_k = 1'b1;
            dec_wr    = 1'b1;
            casez (instr_in[IW-3:IW-6])
               4'b00??: dec_alu = 4'd0;
               4'b1000: dec_alu = 4'd10;
               4'b1001: dec_alu = 4'd4;
               4'b1010: dec_alu = 4'd7;
               4'b110?: dec_alu = 4'd3;
               4'b111?: dec_alu = 4'd2;
               default: dec_alu = 4'd1;
            endcase
         end
         default: begin
            dec_sel_k = 1'b1;
            dec_d     = 1'b1;
            dec_alu   = 4'd0;
            dec_pcl   = 1'b1;
         end
      endcase
   end

   // Flow decision for the instruction executing now; zero_in is judged during Q4.
   always_comb begin
      cur_cls    = ir[IW-1:IW-2];
      cur_op     = ir[IW-3:IW-6];
      cur_branch = (cur_cls == 2'b10);
`ifdef DECODE_SKIP_EN
      cur_skip = ((cur_cls == 2'b00) && ((cur_op == 4'b1011) || (cur_op == 4'b1111)) && zero_in)
              || ((cur_cls == 2'b01) && (cur_op[3:2] == 2'b10) && zero_in)
              || ((cur_cls == 2'b01) && (cur_op[3:2] == 2'b11) && !zero_in);
`else
      cur_skip = 1'b0;
`endif
      state_next = EXEC;
      if ((state == EXEC) && (cur_branch || cur_skip))
         state_next = FLUSH;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= FLUSH;
      else if (phase == 2'd3)
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= 2'd0;
         ir     <= '0;
         alu_op <= 4'd1;
         d      <= 1'b0;
         sel_k  <= 1'b0;
         ram_en <= 1'b0;
         wr_q   <= 1'b0;
         pcl_q  <= 1'b0;
      end else begin
         phase <= phase + 2'd1;
         if (phase == 2'd3) begin
            ir <= instr_in;
            if (state_next == EXEC) begin
               alu_op <= dec_alu;
               d      <= dec_d;
               sel_k  <= dec_sel_k;
               ram_en <= dec_ram_en;
               wr_q   <= dec_wr;
               pcl_q  <= dec_pcl;
            end else begin
               alu_op <= 4'd1;
               d      <= 1'b0;
               sel_k  <= 1'b0;
               ram_en <= 1'b0;
               wr_q   <= 1'b0;
               pcl_q  <= 1'b0;
            end
         end
      end
   end

   assign write_en   = wr_q  && (phase == 2'd3);
   assign pc_load    = pcl_q && (phase == 2'd3);
   assign skip_taken = cur_skip && (state == EXEC) && (phase == 2'd3);
   assign f_addr     = ir[FAW-1:0];
   assign bit_num    = ir[FAW+2:FAW];
   assign k          = ir[KW-1:0];

endmodule

// File: tb/tb_decode_seq.sv
// Randomized bench for decode_seq (FAW=5) against an instruction-level reference model.
module tb_decode_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] instr_in = '0;
   logic        zero_in = 1'b0;
   logic [1:0]  phase;
   logic [3:0]  alu_op;
   logic        d, sel_k, ram_en, write_en, pc_load, skip_taken;
   logic [4:0]  f_addr;
   logic [2:0]  bit_num;
   logic [7:0]  k;

   int total = 0;
   int bad = 0;
   bit checking = 1'b0;

   decode_seq #(.FAW(5)) dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .zero_in(zero_in),
      .phase(phase), .alu_op(alu_op), .d(d), .sel_k(sel_k), .ram_en(ram_en),
      .write_en(write_en), .pc_load(pc_load), .f_addr(f_addr), .bit_num(bit_num),
      .k(k), .skip_taken(skip_taken)
   );

   always #5 clk = ~clk;

`ifdef DECODE_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] alu;
      logic d, sel_k, ram_en, we, pcl, skip;
   } exp_t;

   int byte_alu[16] = '{1, 9, 3, 6, 10, 4, 7, 2, 0, 12, 5, 6, 15, 8, 11, 5};

   // Reference model state: clock within the instruction cycle, flushed flag, executing word.
   int          m_phase;
   bit          m_flush;
   logic [11:0] m_ir;

   function automatic bit model_skips(logic [11:0] w, bit z);
      int op = int'(w[9:6]);
      if (!SKIP) return 1'b0;
      if (w[11:10] == 2'b00 && (op == 11 || op == 15)) return z;
      if (w[11:10] == 2'b01 && op / 4 == 2) return z;
      if (w[11:10] == 2'b01 && op / 4 == 3) return !z;
      return 1'b0;
   endfunction

   function automatic exp_t model_out(logic [11:0] w, bit flush, int ph, bit z);
      exp_t e;
      int op = int'(w[9:6]);
      e = '0;
      e.alu = 4'd1;
      if (flush) return e;
      case (w[11:10])
         2'b00: begin
            e.alu = 4'(byte_alu[op]); e.ram_en = 1; e.d = w[5]; e.we = 1;
         end
         2'b01: begin
            if (op / 4 == 0)      begin e.alu = 4'd14; e.ram_en = 1; e.d = 1; e.we = 1; end
            else if (op / 4 == 1) begin e.alu = 4'd13; e.ram_en = 1; e.d = 1; e.we = 1; end
            else if (SKIP)        begin e.ram_en = 1; e.d = 1; end
         end
         2'b11: begin
            e.sel_k = 1; e.we = 1;
            if (op < 4) e.alu = 4'd0;
            else if (op == 8) e.alu = 4'd10;
            else if (op == 9) e.alu = 4'd4;
            else if (op == 10) e.alu = 4'd7;
            else if (op == 12 || op == 13) e.alu = 4'd3;
            else if (op >= 14) e.alu = 4'd2;
         end
         default: begin
            e.sel_k = 1; e.d = 1; e.alu = 4'd0; e.pcl = 1;
         end
      endcase
      e.skip = model_skips(w, z) && ph == 3;
      e.we   = e.we && ph == 3;
      e.pcl  = e.pcl && ph == 3;
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_flush <= 1'b1;
         m_ir    <= '0;
      end else if (m_phase == 3) begin
         m_phase <= 0;
         m_ir    <= instr_in;
         m_flush <= !m_flush && (m_ir[11:10] == 2'b10 || model_skips(m_ir, zero_in));
      end else begin
         m_phase <= m_phase + 1;
      end
   end

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         exp_t e;
         e = model_out(m_ir, m_flush, m_phase, zero_in);
         check("phase", int'(phase), m_phase);
         check("alu_op", int'(alu_op), int'(e.alu));
         check("d", int'(d), int'(e.d));
         check("sel_k", int'(sel_k), int'(e.sel_k));
         check("ram_en", int'(ram_en), int'(e.ram_en));
         check("write_en", int'(write_en), int'(e.we));
         check("pc_load", int'(pc_load), int'(e.pcl));
         check("skip_taken", int'(skip_taken), int'(e.skip));
         check("f_addr", int'(f_addr), int'(m_ir[4:0]));
         check("bit_num", int'(bit_num), int'(m_ir[7:5]));
         check("k", int'(k), int'(m_ir[7:0]));
      end
   end

   task automatic wait_ph(int p);
      do @(negedge clk); while (m_phase != p);
   endtask

   // Presents the next word and the zero flag for the instruction now executing, from Q3 on.
   task automatic issue(logic [11:0] w, bit z);
      wait_ph(2);
      #1;
      instr_in = w;
      zero_in  = z;
   endtask

   localparam logic [11:0] ADDWF  = 12'h1E3;
   localparam logic [11:0] MOVLW  = 12'hCA5;
   localparam logic [11:0] GOTO   = 12'h842;
   localparam logic [11:0] DECFSZ = 12'h2E2;
   localparam logic [11:0] BTFSS7 = 12'h7F1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 checking = 1'b1;
      @(negedge clk);
      check("rst_phase", int'(phase), 0);
      check("rst_alu_op", int'(alu_op), 1);
      check("rst_ram_en", int'(ram_en), 0);
      check("rst_k", int'(k), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      issue(ADDWF, 0);
      wait_ph(1);
      check("addwf_alu", int'(alu_op), 2);
      check("addwf_d", int'(d), 1);
      check("addwf_ram_en", int'(ram_en), 1);
      check("addwf_f_addr", int'(f_addr), 3);
      check("addwf_we_q2", int'(write_en), 0);
      issue(MOVLW, 0);
      wait_ph(3);
      check("addwf_we_q4", int'(write_en), 1);

      wait_ph(1);
      check("movlw_sel_k", int'(sel_k), 1);
      check("movlw_k", int'(k), 'hA5);
      check("movlw_alu", int'(alu_op), 0);
      check("movlw_d", int'(d), 0);
      check("movlw_ram_en", int'(ram_en), 0);
      issue(GOTO, 0);

      issue(ADDWF, 0);
      wait_ph(3);
      check("goto_pc_load", int'(pc_load), 1);
      check("goto_we", int'(write_en), 0);

      wait_ph(1);
      check("flush_alu", int'(alu_op), 1);
      check("flush_ram_en", int'(ram_en), 0);
      issue(DECFSZ, 0);
      wait_ph(3);
      check("flush_we", int'(write_en), 0);
      check("flush_pc_load", int'(pc_load), 0);

      issue(ADDWF, 1);
      wait_ph(3);
      check("decfsz_z1_skip", int'(skip_taken), SKIP ? 1 : 0);
      wait_ph(1);
      check("after_decfsz_z1_alu", int'(alu_op), SKIP ? 1 : 2);
      issue(DECFSZ, 0);

      issue(ADDWF, 0);
      wait_ph(3);
      check("decfsz_z0_skip", int'(skip_taken), 0);
      wait_ph(1);
      check("after_decfsz_z0_alu", int'(alu_op), 2);
      issue(BTFSS7, 0);

      wait_ph(1);
      check("btfss_bit_num", int'(bit_num), 7);
      issue(ADDWF, 0);
      wait_ph(3);
      check("btfss_skip", int'(skip_taken), SKIP ? 1 : 0);
      check("btfss_we", int'(write_en), 0);
      wait_ph(1);
      check("after_btfss_alu", int'(alu_op), SKIP ? 1 : 2);
      issue(ADDWF, 0);

      wait_ph(1);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("midrst_phase", int'(phase), 0);
            check("midrst_alu", int'(alu_op), 1);
         end
         check("midrst_we", int'(write_en), 0);
         check("midrst_pc_load", int'(pc_load), 0);
      end

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
         issue(12'($urandom), 1'($urandom));
      end

      wait_ph(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
